// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Byte-lane geometry of the 32-bit video word.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } arb_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the single 8-bit async SRAM between video word reads
// and bitmap-download byte writes.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = 19,
    parameter int READ_WAIT = 1,
    parameter int WE_PULSE  = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-3:0] rd_addr,
    output logic              rd_gnt,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [7:0]        sram_din,
    output logic [7:0]        sram_dout,
    output logic              sram_oe,
    output logic              sram_we_n,
    output logic              busy
);

    localparam int WAIT_MAX =
        (READ_WAIT > WE_PULSE) ? READ_WAIT : WE_PULSE;
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_PULSE - 1);
    localparam logic [BYTE_IDX_W-1:0] IDX_LAST =
        BYTE_IDX_W'(BYTES_PER_WORD - 1);

    arb_state_t              state;
    logic [ADDR_W-3:0]       word_addr;
    logic [BYTE_IDX_W-1:0]   byte_idx;
    logic [BYTE_IDX_W-1:0]   nxt_idx;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    last_rd;
    logic [ADDR_W-1:0]       buf_addr;
    logic [7:0]              buf_data;
    logic                    pick_wr;

    // The buffer is full exactly when wr_ready is low.
    assign pick_wr = !wr_ready && (last_rd || !rd_req);
    assign nxt_idx = byte_idx + BYTE_IDX_W'(1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            rd_gnt    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            wr_ready  <= 1'b1;
            sram_addr <= '0;
            sram_dout <= '0;
            sram_oe   <= 1'b0;
            sram_we_n <= 1'b1;
            busy      <= 1'b0;
            last_rd   <= 1'b0;
            word_addr <= '0;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            rd_gnt   <= 1'b0;
            rd_valid <= 1'b0;
            if (wr_valid && wr_ready) begin
                buf_addr <= wr_addr;
                buf_data <= wr_data;
                wr_ready <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (pick_wr) begin
                        state     <= WR_SETUP;
                        sram_addr <= buf_addr;
                        sram_dout <= buf_data;
                        sram_oe   <= 1'b1;
                        wr_ready  <= 1'b1;
                        last_rd   <= 1'b0;
                        busy      <= 1'b1;
                    end else if (rd_req) begin
                        state   <= RD;
                        rd_gnt  <= 1'b1;
                        last_rd <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                RD: begin
                    if (rd_gnt) begin
                        word_addr <= rd_addr;
                        sram_addr <= {rd_addr, {BYTE_IDX_W{1'b0}}};
                        byte_idx  <= '0;
                        wait_cnt  <= '0;
                    end else if (wait_cnt == RD_LAST) begin
                        rd_data[(BYTES_PER_WORD - 1 - int'(byte_idx)) * 8 +: 8]
                            <= sram_din;
                        wait_cnt  <= '0;
                        byte_idx  <= nxt_idx;
                        sram_addr <= {word_addr, nxt_idx};
                        if (byte_idx == IDX_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    sram_we_n <= 1'b0;
                    wait_cnt  <= '0;
                end
                WR_PULSE: begin
                    if (wait_cnt == WE_LAST) begin
                        state     <= WR_HOLD;
                        sram_we_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WR_HOLD: begin
                    state   <= IDLE;
                    sram_oe <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with behavioural async SRAM models.
// A second instance covers the slow-timing parameter build.
module tb_sram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        reset2  = 1'b1;
    logic        rd_req  = 1'b0;
    logic [16:0] rd_addr = '0;
    logic        wr_valid = 1'b0;
    logic [18:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;

    logic        rd_gnt, rd_valid, wr_ready, sram_oe, sram_we_n, busy;
    logic [31:0] rd_data;
    logic [18:0] sram_addr;
    logic [7:0]  sram_din, sram_dout;

    logic        rd_gnt2, rd_valid2, wr_ready2, sram_oe2, sram_we_n2, busy2;
    logic [31:0] rd_data2;
    logic [18:0] sram_addr2;
    logic [7:0]  sram_din2, sram_dout2;

    logic [7:0] mem  [0:524287];
    logic [7:0] mem2 [0:524287];

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk_sys = ~clk_sys;

    assign sram_din  = mem[sram_addr];
    assign sram_din2 = mem2[sram_addr2];

    always @(posedge sram_we_n)
        if (sram_oe === 1'b1) mem[sram_addr] <= sram_dout;

    always @(posedge sram_we_n2)
        if (sram_oe2 === 1'b1) mem2[sram_addr2] <= sram_dout2;

    sram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .sram_oe(sram_oe), .sram_we_n(sram_we_n), .busy(busy)
    );

    sram_arbiter #(.READ_WAIT(3), .WE_PULSE(2)) dut_slow (
        .clk_sys(clk_sys), .reset(reset2),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready2), .sram_addr(sram_addr2),
        .sram_din(sram_din2), .sram_dout(sram_dout2),
        .sram_oe(sram_oe2), .sram_we_n(sram_we_n2), .busy(busy2)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_read(input logic [16:0] a, output logic [31:0] d);
        int n;
        rd_addr = a;
        rd_req  = 1'b1;
        n = 0;
        tick();
        while (!rd_gnt && n < 50) begin tick(); n++; end
        rd_req = 1'b0;
        n = 0;
        while (!rd_valid && n < 50) begin tick(); n++; end
        chk("rd_timeout", {31'd0, rd_valid}, 32'd1);
        d = rd_data;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(busy == 1'b0 && wr_ready) && n < 100) begin
            tick();
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  ev[$];
        logic        prev_oe, acc, stable;
        int lat, oe_cnt, we_cnt, wi, rise, acc_at;

        mem[19'h100] = 8'h11; mem[19'h101] = 8'h22;
        mem[19'h102] = 8'h33; mem[19'h103] = 8'h44;
        mem[19'h7FFFC] = 8'h01; mem[19'h7FFFD] = 8'h02;
        mem[19'h7FFFE] = 8'h03; mem[19'h300] = 8'h00;
        mem2[19'h100] = 8'h11; mem2[19'h101] = 8'h22;
        mem2[19'h102] = 8'h33; mem2[19'h103] = 8'h44;

        tick(); tick();
        chk("rst_gnt", {31'd0, rd_gnt}, 32'd0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_data", rd_data, 32'd0);
        chk("rst_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_addr", {13'd0, sram_addr}, 32'd0);
        chk("rst_oe", {31'd0, sram_oe}, 32'd0);
        chk("rst_we", {31'd0, sram_we_n}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick();

        // word read with single-cycle waits
        rd_addr = 17'h40;
        rd_req  = 1'b1;
        tick();
        chk("t1_gnt", {31'd0, rd_gnt}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        rd_req = 1'b0;
        tick();
        chk("t1_addr", {13'd0, sram_addr}, 32'h100);
        chk("t1_oe", {31'd0, sram_oe}, 32'd0);
        lat = 1;
        while (!rd_valid && lat < 50) begin tick(); lat++; end
        chk("t1_lat", lat, 5);
        chk("t1_data", rd_data, 32'h11223344);
        chk("t1_idle", {31'd0, busy}, 32'd0);

        // byte write at top of address space
        wr_valid = 1'b1;
        wr_addr  = 19'h7FFFF;
        wr_data  = 8'hA5;
        tick();
        chk("t2_full", {31'd0, wr_ready}, 32'd0);
        wr_valid = 1'b0;
        tick();
        chk("t2_oe", {31'd0, sram_oe}, 32'd1);
        chk("t2_we_setup", {31'd0, sram_we_n}, 32'd1);
        chk("t2_addr", {13'd0, sram_addr}, 32'h7FFFF);
        chk("t2_dout", {24'd0, sram_dout}, 32'hA5);
        chk("t2_ready", {31'd0, wr_ready}, 32'd1);
        oe_cnt = 1; we_cnt = 0; stable = 1'b1;
        while (sram_oe && oe_cnt < 20) begin
            tick();
            if (sram_oe) begin
                oe_cnt++;
                if (!sram_we_n) we_cnt++;
                if (sram_addr != 19'h7FFFF || sram_dout != 8'hA5)
                    stable = 1'b0;
            end
        end
        chk("t2_oe_cycles", oe_cnt, 3);
        chk("t2_we_cycles", we_cnt, 1);
        chk("t2_stable", {31'd0, stable}, 32'd1);
        chk("t2_mem", {24'd0, mem[19'h7FFFF]}, 32'hA5);
        do_read(17'h1FFFF, d);
        chk("t2_readback", d, 32'h010203A5);

        // continuous reads with pending writes alternate
        rd_addr = 17'h40;
        rd_req  = 1'b1;
        wi = 0;
        prev_oe = sram_oe;
        for (int c = 0; c < 300 && ev.size() < 7; c++) begin
            wr_valid = (wi < 3);
            wr_addr  = 19'h200 + 19'(wi);
            wr_data  = 8'h60 + 8'(wi);
            acc = wr_valid && wr_ready;
            tick();
            if (acc) wi++;
            if (rd_gnt) ev.push_back(8'h52);
            if (sram_oe && !prev_oe) ev.push_back(8'h57);
            prev_oe = sram_oe;
        end
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        chk("t3_count", ev.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < ev.size())
                chk($sformatf("t3_ev%0d", i), {24'd0, ev[i]},
                    (i % 2 == 0) ? 32'h52 : 32'h57);
        wait_idle();
        for (int i = 0; i < 3; i++)
            chk($sformatf("t3_mem%0d", i), {24'd0, mem[19'h200 + 19'(i)]},
                32'h60 + i);

        // reset during a read, with a write buffered
        rd_addr  = 17'h40;
        rd_req   = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 19'h300;
        wr_data  = 8'h77;
        tick();
        chk("t4_gnt", {31'd0, rd_gnt}, 32'd1);
        rd_req   = 1'b0;
        wr_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_we", {31'd0, sram_we_n}, 32'd1);
        chk("t4_oe", {31'd0, sram_oe}, 32'd0);
        chk("t4_ready", {31'd0, wr_ready}, 32'd1);
        chk("t4_data", rd_data, 32'd0);
        lat = 0; oe_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (rd_valid) lat++;
            if (sram_oe) oe_cnt++;
            tick();
        end
        chk("t4_no_valid", lat, 0);
        chk("t4_no_write", oe_cnt, 0);
        chk("t4_mem", {24'd0, mem[19'h300]}, 32'd0);

        // second write offered while the buffer is full
        rd_addr  = 17'h40;
        rd_req   = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 19'h400;
        wr_data  = 8'h5A;
        tick();
        chk("t6_gnt", {31'd0, rd_gnt}, 32'd1);
        rd_req  = 1'b0;
        wr_addr = 19'h401;
        wr_data = 8'hC3;
        chk("t6_full", {31'd0, wr_ready}, 32'd0);
        rise = -1; acc_at = -1;
        prev_oe = sram_oe;
        for (int n = 0; n < 40 && acc_at < 0; n++) begin
            tick();
            if (sram_oe && !prev_oe) rise = n;
            prev_oe = sram_oe;
            if (wr_ready) acc_at = n;
        end
        chk("t6_accept_cycle", acc_at, rise);
        chk("t6_rise", rise, 5);
        tick();
        wr_valid = 1'b0;
        chk("t6_held", {31'd0, wr_ready}, 32'd0);
        wait_idle();
        chk("t6_mem_a", {24'd0, mem[19'h400]}, 32'h5A);
        chk("t6_mem_b", {24'd0, mem[19'h401]}, 32'hC3);

        // slow build: READ_WAIT=3, WE_PULSE=2
        reset2 = 1'b0;
        tick();
        rd_addr = 17'h40;
        rd_req  = 1'b1;
        lat = 0;
        tick();
        while (!rd_gnt2 && lat < 50) begin tick(); lat++; end
        chk("t5_gnt", {31'd0, rd_gnt2}, 32'd1);
        rd_req = 1'b0;
        lat = 0;
        while (!rd_valid2 && lat < 60) begin tick(); lat++; end
        chk("t5_lat", lat, 13);
        chk("t5_data", rd_data2, 32'h11223344);
        wr_valid = 1'b1;
        wr_addr  = 19'h500;
        wr_data  = 8'h3C;
        chk("t5_ready", {31'd0, wr_ready2}, 32'd1);
        tick();
        wr_valid = 1'b0;
        oe_cnt = 0; we_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (sram_oe2) oe_cnt++;
            if (!sram_we_n2) we_cnt++;
        end
        chk("t5_we_cycles", we_cnt, 2);
        chk("t5_oe_cycles", oe_cnt, 4);
        chk("t5_mem", {24'd0, mem2[19'h500]}, 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
